// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two hosts, the arbiter and the memory device.
// master is the arbiter's view, slave is the view of the surrounding hosts and device.
interface mem_bus_arbiter_if #(parameter int size = 16);
   logic            h0_req, h0_read, h0_grant, h0_done, h0_err;
   logic [size-1:0] h0_addr, h0_wdata, h0_rdata;
   logic            h1_req, h1_read, h1_grant, h1_done, h1_err;
   logic [size-1:0] h1_addr, h1_wdata, h1_rdata;
   logic            mem_ready, mem_cs, mem_read, busy;
   logic [size-1:0] mem_rdata, mem_addr, mem_wdata;

   modport master (
      input  h0_req, h0_read, h0_addr, h0_wdata,
      input  h1_req, h1_read, h1_addr, h1_wdata,
      input  mem_ready, mem_rdata,
      output h0_grant, h0_done, h0_err, h0_rdata,
      output h1_grant, h1_done, h1_err, h1_rdata,
      output mem_cs, mem_read, mem_addr, mem_wdata, busy
   );

   modport slave (
      output h0_req, h0_read, h0_addr, h0_wdata,
      output h1_req, h1_read, h1_addr, h1_wdata,
      output mem_ready, mem_rdata,
      input  h0_grant, h0_done, h0_err, h0_rdata,
      input  h1_grant, h1_done, h1_err, h1_rdata,
      input  mem_cs, mem_read, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin two-host arbiter for a single memory port, with a mem_ready timeout.
// Every output is decoded from registered state; nothing passes straight from inputs.
module mem_bus_arbiter #(
   parameter int size    = 16,
   parameter int TIMEOUT = 8
) (
   input logic             clk,
   input logic             rst,
   mem_bus_arbiter_if.master bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

   state_t          state, nxt;
   logic            owner, last, lat_read;
   logic [size-1:0] addr_q, wdata_q, rdata0, rdata1;
   logic [7:0]      cnt;
   logic            win, win_vld, expired;

   // Tie goes to the host that was not served last.
   assign win_vld = bus.h0_req | bus.h1_req;
   assign win     = (bus.h0_req & bus.h1_req) ? ~last : bus.h1_req;
   assign expired = (cnt == 8'(TIMEOUT - 1));

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (win_vld) nxt = ACCESS;
         ACCESS:  if (bus.mem_ready) nxt = DONE;
                  else if (expired) nxt = ERR;
         DONE:    nxt = IDLE;
         ERR:     nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         owner    <= 1'b0;
         last     <= 1'b1;
         lat_read <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata0   <= '0;
         rdata1   <= '0;
         cnt      <= '0;
      end else begin
         state <= nxt;
         case (state)
            IDLE: if (win_vld) begin
               owner    <= win;
               lat_read <= win ? bus.h1_read  : bus.h0_read;
               addr_q   <= win ? bus.h1_addr  : bus.h0_addr;
               wdata_q  <= win ? bus.h1_wdata : bus.h0_wdata;
               cnt      <= '0;
            end
            ACCESS: begin
               if (bus.mem_ready) begin
                  if (lat_read && !owner) rdata0 <= bus.mem_rdata;
                  if (lat_read &&  owner) rdata1 <= bus.mem_rdata;
               end else if (!expired) begin
                  cnt <= cnt + 8'd1;
               end
            end
            DONE, ERR: last <= owner;
            default: ;
         endcase
      end
   end

   // cnt is cleared on every win, so cnt==0 marks the first ACCESS cycle.
   logic in_acc, first, fin, fail;
   assign in_acc = (state == ACCESS);
   assign first  = in_acc && (cnt == '0);
   assign fin    = (state == DONE) || (state == ERR);
   assign fail   = (state == ERR);

   assign bus.mem_cs    = in_acc;
   assign bus.mem_read  = in_acc & lat_read;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.busy      = (state != IDLE);

   assign bus.h0_grant = first & ~owner;
   assign bus.h1_grant = first &  owner;
   assign bus.h0_done  = fin   & ~owner;
   assign bus.h1_done  = fin   &  owner;
   assign bus.h0_err   = fail  & ~owner;
   assign bus.h1_err   = fail  &  owner;
   assign bus.h0_rdata = rdata0;
   assign bus.h1_rdata = rdata1;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: reset, read, write, timeout, boundaries, contention.
module tb_mem_bus_arbiter;
   logic clk = 1'b0;
   logic rst;
   int   n_chk = 0, n_fail = 0;

   mem_bus_arbiter_if #(.size(16)) bif ();
   mem_bus_arbiter #(.size(16), .TIMEOUT(8)) dut (.clk(clk), .rst(rst), .bus(bif));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Step one edge; drives and samples both happen 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int ord[4];
   int ng;
   logic open;

   initial begin
      rst = 1'b0;
      bif.h0_req = 1'b1; bif.h0_read = 1'b1; bif.h0_addr = 16'h0010; bif.h0_wdata = 16'h0;
      bif.h1_req = 1'b0; bif.h1_read = 1'b0; bif.h1_addr = 16'h0;    bif.h1_wdata = 16'h0;
      bif.mem_ready = 1'b0; bif.mem_rdata = 16'h0;
      tick(); tick();
      chk("rst_cs",    bif.mem_cs, 0);
      chk("rst_busy",  bif.busy, 0);
      chk("rst_grant", bif.h0_grant, 0);
      chk("rst_done",  bif.h0_done | bif.h1_done | bif.h0_err | bif.h1_err, 0);
      chk("rst_addr",  bif.mem_addr, 0);
      chk("rst_rdata", bif.h0_rdata, 0);

      // single read, ready in third ACCESS cycle
      rst = 1'b1;
      tick();
      chk("rd_grant", bif.h0_grant, 1);
      chk("rd_cs1",   bif.mem_cs, 1);
      chk("rd_dir",   bif.mem_read, 1);
      chk("rd_addr",  bif.mem_addr, 16'h0010);
      bif.h0_req = 1'b0;
      tick();
      chk("rd_cs2",    bif.mem_cs, 1);
      chk("rd_grant2", bif.h0_grant, 0);
      tick();
      chk("rd_cs3", bif.mem_cs, 1);
      bif.mem_ready = 1'b1; bif.mem_rdata = 16'hBEEF;
      tick();
      bif.mem_ready = 1'b0;
      chk("rd_cs_off", bif.mem_cs, 0);
      chk("rd_done",   bif.h0_done, 1);
      chk("rd_err",    bif.h0_err, 0);
      chk("rd_rdata",  bif.h0_rdata, 16'hBEEF);
      tick();
      chk("rd_done_1cyc", bif.h0_done, 0);
      chk("rd_idle",      bif.busy, 0);

      // h1 write
      bif.h1_req = 1'b1; bif.h1_read = 1'b0; bif.h1_addr = 16'h0020; bif.h1_wdata = 16'h1234;
      tick();
      bif.h1_req = 1'b0;
      chk("wr_grant",  bif.h1_grant, 1);
      chk("wr_ngrant", bif.h0_grant, 0);
      chk("wr_dir",    bif.mem_read, 0);
      chk("wr_addr",   bif.mem_addr, 16'h0020);
      chk("wr_wdata",  bif.mem_wdata, 16'h1234);
      bif.mem_ready = 1'b1; bif.mem_rdata = 16'hDEAD;
      tick();
      bif.mem_ready = 1'b0;
      chk("wr_done",  bif.h1_done, 1);
      chk("wr_ndone", bif.h0_done, 0);
      chk("wr_rdata", bif.h1_rdata, 0);
      tick();

      // timeout on h0 read
      bif.h0_req = 1'b1; bif.h0_addr = 16'h0030;
      tick();
      bif.h0_req = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("to_cs%0d", i), bif.mem_cs, 1);
         chk($sformatf("to_nodone%0d", i), bif.h0_done, 0);
         tick();
      end
      chk("to_cs_off", bif.mem_cs, 0);
      chk("to_done",   bif.h0_done, 1);
      chk("to_err",    bif.h0_err, 1);
      chk("to_rdata",  bif.h0_rdata, 16'hBEEF);
      tick();
      chk("to_idle", bif.busy, 0);

      // prompt read after timeout
      bif.h0_req = 1'b1; bif.h0_addr = 16'h0040;
      tick();
      bif.h0_req = 1'b0;
      chk("rec_grant", bif.h0_grant, 1);
      bif.mem_ready = 1'b1; bif.mem_rdata = 16'h5A5A;
      tick();
      bif.mem_ready = 1'b0;
      chk("rec_done",  bif.h0_done, 1);
      chk("rec_err",   bif.h0_err, 0);
      chk("rec_rdata", bif.h0_rdata, 16'h5A5A);
      tick();

      // ready on the 8th ACCESS cycle still completes normally
      bif.h1_req = 1'b1; bif.h1_read = 1'b1; bif.h1_addr = 16'h0050;
      tick();
      bif.h1_req = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      chk("b8_cs", bif.mem_cs, 1);
      bif.mem_ready = 1'b1; bif.mem_rdata = 16'h0F0F;
      tick();
      bif.mem_ready = 1'b0;
      chk("b8_done",  bif.h1_done, 1);
      chk("b8_err",   bif.h1_err, 0);
      chk("b8_rdata", bif.h1_rdata, 16'h0F0F);
      tick();

      // ready while idle is ignored
      bif.mem_ready = 1'b1; bif.mem_rdata = 16'h7777;
      tick();
      chk("idle_rdy_done", bif.h0_done | bif.h1_done, 0);
      chk("idle_rdy_busy", bif.busy, 0);
      tick();
      bif.mem_ready = 1'b0;
      chk("idle_rdy_rdata", bif.h1_rdata, 16'h0F0F);

      // reset in the middle of ACCESS
      bif.h0_req = 1'b1; bif.h0_addr = 16'h0060;
      tick();
      chk("mr_cs", bif.mem_cs, 1);
      rst = 1'b0; bif.h0_req = 1'b0;
      tick();
      chk("mr_cs_off", bif.mem_cs, 0);
      chk("mr_busy",   bif.busy, 0);
      chk("mr_nodone", bif.h0_done, 0);
      rst = 1'b1;
      tick();
      chk("mr_nodone2", bif.h0_done, 0);
      chk("mr_rdata",   bif.h0_rdata, 0);

      // contention: both held, ready always high -> h0,h1,h0,h1
      bif.h0_req = 1'b1; bif.h1_req = 1'b1; bif.mem_ready = 1'b1;
      ng = 0; open = 1'b0;
      for (int c = 0; c < 40 && ng < 4; c++) begin
         tick();
         if (bif.h0_done | bif.h1_done) open = 1'b0;
         if (bif.h0_grant | bif.h1_grant) begin
            chk("ct_overlap", bif.h0_grant & bif.h1_grant, 0);
            chk("ct_done_first", open, 0);
            ord[ng] = bif.h1_grant ? 1 : 0;
            ng++;
            open = 1'b1;
         end
      end
      bif.h0_req = 1'b0; bif.h1_req = 1'b0;
      chk("ct_count", ng, 4);
      for (int i = 0; i < 4; i++) chk($sformatf("ct_order%0d", i), ord[i], i % 2);
      tick(); tick();
      bif.mem_ready = 1'b0;
      chk("ct_idle", bif.busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Two-host arbiter that shares a single memory device port between two independent requesters.
- Arbitrates round-robin and latches the winner's address, direction and write data.
- Drives the mem_cs/mem_read/mem_ready handshake and returns read data and a completion or error pulse to the owner.
- Sits between two host-side controllers and the memory device, in place of a direct device_controller-to-memory connection.
- Bounds every access with a mem_ready timeout.

Parameters:
size, 16, width of address and data buses
TIMEOUT, 8, maximum ACCESS cycles without mem_ready before abort (1..255)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-low (rst=0 at a clk edge resets)
h0_req  input  1  host 0 request, held until h0_done
h0_read  input  1  host 0 direction: 1 = read, 0 = write
h0_addr  input  size  host 0 address
h0_wdata  input  size  host 0 write data
h0_grant  output  1  one-cycle pulse, host 0 transaction started
h0_done  output  1  one-cycle pulse, host 0 transaction finished
h0_err  output  1  one-cycle pulse with h0_done on timeout
h0_rdata  output  size  host 0 last read data
h1_req, h1_read, h1_addr, h1_wdata, h1_grant, h1_done, h1_err, h1_rdata: same as host 0, for host 1
mem_ready  input  1  device access complete
mem_rdata  input  size  device read data, valid with mem_ready
mem_cs  output  1  device select
mem_read  output  1  device direction: 1 = read, 0 = write
mem_addr  output  size  latched address
mem_wdata  output  size  latched write data
busy  output  1  high in any state other than IDLE

Behaviour:
- All outputs are registered or decoded from registered state. No combinational path from inputs to outputs.
- Reset (rst=0 at an edge): state=IDLE; all outputs 0; rdata registers 0; timeout counter 0; last-served pointer = host 1, so host 0 wins the first tie.
  - Applies mid-transaction: the access is abandoned with no done pulse, and mem_cs=0 in the following cycle.
- States: IDLE, ACCESS, DONE, ERR.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req high: that host wins.
  - Both high: the host not last served wins.
  - On a win, latch owner, addr, wdata and read; clear the counter; go to ACCESS.
- ACCESS:
  - mem_cs=1 and mem_read=latched read.
  - The owner's grant is high in the first ACCESS cycle only.
  - mem_ready=1: capture mem_rdata into the owner's rdata (reads only; writes leave rdata unchanged); go to DONE.
  - Otherwise: if counter==TIMEOUT-1, go to ERR; else increment the counter.
  - mem_ready on the same cycle the timeout is reached: ready wins, go to DONE.
- DONE: mem_cs=0; owner done=1 for one cycle; last-served pointer=owner; go to IDLE.
- ERR: mem_cs=0; owner done=1 and err=1 for one cycle; rdata unchanged; last-served pointer=owner; go to IDLE.
- Latency:
  - A req sampled in IDLE at edge N gives mem_cs and grant in cycle N+1.
  - mem_ready in the first ACCESS cycle gives done in cycle N+2 and IDLE in cycle N+3.
  - Minimum transaction: 3 cycles. Maximum: TIMEOUT+2 cycles.
- Requester rules:
  - Changes to req, addr, read or wdata after grant are ignored until the transaction finishes.
  - Dropping req mid-access does not abort the access.
  - req still high when IDLE is re-entered starts a new transaction.
- mem_ready outside ACCESS is ignored.
- mem_addr and mem_wdata hold their last latched value outside ACCESS.
- mem_read=0 whenever mem_cs=0.
- The non-owner's grant, done and err stay 0 throughout a transaction.

Test Plan:
- Reset: hold rst=0 for 2 cycles with h0_req=1 -> all outputs 0, busy=0. Release -> h0_grant and mem_cs in the next cycle.
- Single read: h0 reads addr 0x0010; mem_ready=1 with mem_rdata=0xBEEF two cycles into ACCESS -> mem_addr=0x0010, mem_read=1, mem_cs high for exactly 3 cycles, h0_rdata=0xBEEF, one h0_done pulse, h0_err=0.
- Write: h1 writes 0x1234 to 0x0020 -> mem_read=0, mem_wdata=0x1234, h1_done pulse, h1_rdata unchanged.
- Contention: h0_req and h1_req both high and held after reset -> service order h0, h1, h0, h1. Grants never overlap, and each host's done precedes the other host's grant.
- Timeout: h0 read with mem_ready held 0 -> mem_cs high for exactly 8 cycles, then h0_done=h0_err=1 for one cycle, h0_rdata unchanged. A following h0 read with prompt mem_ready completes normally.
- Boundaries:
  - mem_ready asserted on the 8th ACCESS cycle -> DONE with no error.
  - mem_ready pulsed while in IDLE -> ignored, no done.
  - rst=0 in the middle of ACCESS -> mem_cs=0 the next cycle, no done pulse.
